store_buffer: RTL and testbench

- Write-side counterpart to the memory-stage load path: accepts SB/SH/SW requests from the memory stage and aligns the data into word-lane form with byte strobes.
- Queues stores in a small in-order FIFO and drains them to the L1 data cache through a req/ack handshake.
- Flags loads that hit a word with a pending store, so the hazard unit can stall the load until that store drains.

---
 rtl/store_buffer.sv | 133 +++++++++++++
 tb/tb_store_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: aligns SB/SH/SW stores into word lanes with byte strobes,
// queues them in order and drains them to the L1 data cache over req/ack.
// Also flags loads whose word matches a store that is still pending.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid_i,
   input  logic [2:0]  st_funct3_i,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   output logic        st_ready_o,
   input  logic        ld_valid_i,
   input  logic [31:0] ld_addr_i,
   output logic        ld_hazard_o,
   output logic        L1DC_wreq_o,
   output logic [31:0] L1DC_waddr_o,
   output logic [31:0] L1DC_wdata_o,
   output logic [3:0]  L1DC_wstrb_o,
   input  logic        L1DC_wack_i,
   output logic        sb_empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [29:0]      ent_addr [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [3:0]       ent_strb [DEPTH];
   logic [DEPTH-1:0] ent_valid;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic        enq_legal;
   logic [31:0] enq_data;
   logic [3:0]  enq_strb;
   logic        enq;
   logic        pop;
   logic        head_valid;
   logic        hit;

   // The low byte-offset bits of a load play no part in the word compare.
   logic unused_ld_bits;
   assign unused_ld_bits = &{1'b0, ld_addr_i[1:0]};

   // Lane alignment and strobe generation for the incoming store.
   always_comb begin
      enq_legal = 1'b0;
      enq_data  = '0;
      enq_strb  = '0;
      case (st_funct3_i)
         3'b000: begin
            enq_legal = 1'b1;
            enq_data  = {4{st_data_i[7:0]}};
            enq_strb  = 4'b0001 << st_addr_i[1:0];
         end
         3'b001: begin
            // Any nonzero offset selects the upper half, as the load path does.
            enq_legal = 1'b1;
            enq_data  = {2{st_data_i[15:0]}};
            enq_strb  = (st_addr_i[1:0] == 2'b00) ? 4'b0011 : 4'b1100;
         end
         3'b010: begin
            enq_legal = 1'b1;
            enq_data  = st_data_i;
            enq_strb  = 4'b1111;
         end
         default: begin
            enq_legal = 1'b0;
         end
      endcase
   end

   assign head_valid  = (count != '0);
   assign st_ready_o  = (count != FULL);
   assign sb_empty_o  = ~head_valid;
   assign L1DC_wreq_o = head_valid;
   assign enq         = st_valid_i && st_ready_o && enq_legal;
   assign pop         = head_valid && L1DC_wack_i;

   // Head entry presented to the cache; forced to zero while empty.
   assign L1DC_waddr_o = head_valid ? {ent_addr[rd_ptr], 2'b00} : '0;
   assign L1DC_wdata_o = head_valid ? ent_data[rd_ptr] : '0;
   assign L1DC_wstrb_o = head_valid ? ent_strb[rd_ptr] : '0;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (enq && !pop)      count <= count + CNT_W'(1);
         else if (pop && !enq) count <= count - CNT_W'(1);
      end
   end

   // Per-entry valid bits, used by the load hazard compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid <= '0;
      end else begin
         if (pop) ent_valid[rd_ptr] <= 1'b0;
         if (enq) ent_valid[wr_ptr] <= 1'b1;
      end
   end

   // Entry payload storage; contents are qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (enq) begin
         ent_addr[wr_ptr] <= st_addr_i[31:2];
         ent_data[wr_ptr] <= enq_data;
         ent_strb[wr_ptr] <= enq_strb;
      end
   end

   // Word-granular match of the load against every pending store.
   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && (ent_addr[i] == ld_addr_i[31:2])) hit = 1'b1;
      end
   end

   assign ld_hazard_o = ld_valid_i && hit;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model of the buffer.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        st_valid_i;
   logic [2:0]  st_funct3_i;
   logic [31:0] st_addr_i;
   logic [31:0] st_data_i;
   logic        st_ready_o;
   logic        ld_valid_i;
   logic [31:0] ld_addr_i;
   logic        ld_hazard_o;
   logic        L1DC_wreq_o;
   logic [31:0] L1DC_waddr_o;
   logic [31:0] L1DC_wdata_o;
   logic [3:0]  L1DC_wstrb_o;
   logic        L1DC_wack_i;
   logic        sb_empty_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } ent_t;

   ent_t q[$];

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .st_valid_i   (st_valid_i),
      .st_funct3_i  (st_funct3_i),
      .st_addr_i    (st_addr_i),
      .st_data_i    (st_data_i),
      .st_ready_o   (st_ready_o),
      .ld_valid_i   (ld_valid_i),
      .ld_addr_i    (ld_addr_i),
      .ld_hazard_o  (ld_hazard_o),
      .L1DC_wreq_o  (L1DC_wreq_o),
      .L1DC_waddr_o (L1DC_waddr_o),
      .L1DC_wdata_o (L1DC_wdata_o),
      .L1DC_wstrb_o (L1DC_wstrb_o),
      .L1DC_wack_i  (L1DC_wack_i),
      .sb_empty_o   (sb_empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference alignment rules; returns 1 when funct3 names a real store.
   function automatic bit model_align(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] d, output ent_t e);
      int b;
      b = int'(a & 32'h3);
      e.addr = a & ~32'h3;
      e.data = '0;
      e.strb = '0;
      if (f3 == 3'd0) begin
         e.data = {24'h0, d[7:0]} * 32'h0101_0101;
         e.strb = 4'(1 << b);
         return 1'b1;
      end else if (f3 == 3'd1) begin
         e.data = {16'h0, d[15:0]} * 32'h0001_0001;
         e.strb = (b == 0) ? 4'h3 : 4'hC;
         return 1'b1;
      end else if (f3 == 3'd2) begin
         e.data = d;
         e.strb = 4'hF;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic compare_outputs();
      bit haz;
      haz = 1'b0;
      foreach (q[i]) if ((q[i].addr >> 2) == (ld_addr_i >> 2)) haz = 1'b1;
      check("st_ready", 32'(st_ready_o), 32'(q.size() != DEPTH));
      check("wreq",     32'(L1DC_wreq_o), 32'(q.size() != 0));
      check("empty",    32'(sb_empty_o),  32'(q.size() == 0));
      check("hazard",   32'(ld_hazard_o), 32'(ld_valid_i && haz));
      if (q.size() != 0) begin
         check("waddr", L1DC_waddr_o, q[0].addr);
         check("wdata", L1DC_wdata_o, q[0].data);
         check("wstrb", 32'(L1DC_wstrb_o), 32'(q[0].strb));
      end else begin
         check("waddr_idle", L1DC_waddr_o, 32'h0);
         check("wdata_idle", L1DC_wdata_o, 32'h0);
         check("wstrb_idle", 32'(L1DC_wstrb_o), 32'h0);
      end
   endtask

   // One clock of stimulus: drive, check against the model, then advance the model.
   task automatic drive_cycle(input logic sv, input logic [2:0] f3, input logic [31:0] sa,
                              input logic [31:0] sd, input logic lv, input logic [31:0] la,
                              input logic ack);
      ent_t e;
      bit   legal;
      bit   do_pop;
      bit   do_enq;
      @(negedge clk);
      st_valid_i  = sv;
      st_funct3_i = f3;
      st_addr_i   = sa;
      st_data_i   = sd;
      ld_valid_i  = lv;
      ld_addr_i   = la;
      L1DC_wack_i = ack;
      #1;
      compare_outputs();
      legal  = model_align(f3, sa, sd, e);
      do_pop = ack && (q.size() != 0);
      do_enq = sv && legal && (q.size() < DEPTH);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_enq) q.push_back(e);
   endtask

   task automatic idle(input logic ack);
      drive_cycle(1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0, ack);
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      drive_cycle(1'b1, f3, a, d, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic expect_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
      #1;
      check({tag, "_wreq"},  32'(L1DC_wreq_o), 32'h1);
      check({tag, "_waddr"}, L1DC_waddr_o, a);
      check({tag, "_wdata"}, L1DC_wdata_o, d);
      check({tag, "_wstrb"}, 32'(L1DC_wstrb_o), 32'(s));
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 4 * DEPTH) begin
         idle(1'b1);
         guard++;
      end
      check("drain_done", 32'(q.size()), 32'h0);
   endtask

   initial begin
      rst         = 1'b1;
      st_valid_i  = 1'b0;
      st_funct3_i = 3'd0;
      st_addr_i   = '0;
      st_data_i   = '0;
      ld_valid_i  = 1'b0;
      ld_addr_i   = '0;
      L1DC_wack_i = 1'b0;
      #1;
      check("rst_wreq",  32'(L1DC_wreq_o), 32'h0);
      check("rst_ready", 32'(st_ready_o), 32'h1);
      check("rst_empty", 32'(sb_empty_o), 32'h1);
      check("rst_waddr", L1DC_waddr_o, 32'h0);
      check("rst_wstrb", 32'(L1DC_wstrb_o), 32'h0);
      check("rst_haz",   32'(ld_hazard_o), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single SW held without ack, then one ack pulse.
      store(3'd2, 32'h0000_1004, 32'hDEAD_BEEF);
      expect_head("sw", 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      repeat (5) idle(1'b0);
      expect_head("sw_hold", 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      idle(1'b1);
      #1;
      check("sw_gone_wreq",  32'(L1DC_wreq_o), 32'h0);
      check("sw_gone_empty", 32'(sb_empty_o), 32'h1);
      idle(1'b1);

      // Byte stores into every lane of one word.
      for (int i = 0; i < 4; i++) store(3'd0, 32'h100 + 32'(i), 32'h0000_00A5);
      for (int i = 0; i < 4; i++) begin
         expect_head("sb", 32'h100, 32'hA5A5_A5A5, 4'(1 << i));
         idle(1'b1);
      end
      #1;
      check("sb_empty", 32'(sb_empty_o), 32'h1);

      // Halfword stores at offset 2 and offset 1 both land in the upper half.
      store(3'd1, 32'h202, 32'h0000_1234);
      store(3'd1, 32'h201, 32'h0000_1234);
      expect_head("sh202", 32'h200, 32'h1234_1234, 4'hC);
      idle(1'b1);
      expect_head("sh201", 32'h200, 32'h1234_1234, 4'hC);
      idle(1'b1);

      // Illegal funct3 is ignored.
      store(3'd3, 32'h400, 32'h1111_1111);
      #1;
      check("illegal_empty", 32'(sb_empty_o), 32'h1);

      // Full buffer refuses a store even when an ack pops the same cycle.
      for (int i = 0; i < 4; i++) store(3'd2, 32'h600 + 32'(4 * i), 32'(i));
      #1;
      check("full_ready", 32'(st_ready_o), 32'h0);
      drive_cycle(1'b1, 3'd2, 32'h700, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
      #1;
      check("after_full_ready", 32'(st_ready_o), 32'h1);
      expect_head("after_full", 32'h604, 32'h1, 4'hF);
      repeat (3) idle(1'b1);
      #1;
      check("full_count3", 32'(sb_empty_o), 32'h1);

      // Load hazard against a pending SW.
      store(3'd2, 32'h300, 32'hCAFE_F00D);
      drive_cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h302, 1'b0);
      ld_addr_i = 32'h302;
      #1;
      check("haz_hit", 32'(ld_hazard_o), 32'h1);
      ld_addr_i = 32'h304;
      #1;
      check("haz_miss", 32'(ld_hazard_o), 32'h0);
      drive_cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h302, 1'b1);
      ld_addr_i = 32'h302;
      #1;
      check("haz_drained", 32'(ld_hazard_o), 32'h0);

      // Asynchronous reset mid-cycle with entries pending.
      for (int i = 0; i < 3; i++) store(3'd2, 32'h800 + 32'(4 * i), 32'hBAD0_0000 + 32'(i));
      @(negedge clk);
      st_valid_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_wreq",  32'(L1DC_wreq_o), 32'h0);
      check("arst_empty", 32'(sb_empty_o), 32'h1);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      store(3'd2, 32'h500, 32'h0BAD_CAFE);
      expect_head("post_rst", 32'h500, 32'h0BAD_CAFE, 4'hF);
      idle(1'b1);
      #1;
      check("post_rst_empty", 32'(sb_empty_o), 32'h1);

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         drive_cycle(($urandom_range(0, 9) < 6),
                     3'($urandom_range(0, 3)),
                     32'h1000 + 32'($urandom_range(0, 31)),
                     $urandom,
                     ($urandom_range(0, 1) == 1),
                     32'h1000 + 32'($urandom_range(0, 35)),
                     ($urandom_range(0, 1) == 1));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
